// File: rtl/wspad_pkg.sv
// Shared types and elaboration helpers for the PE weight scratchpad.
// Optional feature macro used across this slice: WSPAD_PARITY_EN.
package wspad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    STREAM,
    DONE
  } state_t;

  // Weights held per kernel.
  function automatic int num_wght(input int kernel_size);
    return kernel_size * kernel_size;
  endfunction

  // Number of times the kernel is replayed across one activation row.
  function automatic int num_pass(input int act_size, input int kernel_size);
    return act_size - kernel_size + 1;
  endfunction

  // Index width needed to address a memory of the given depth.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pe_wght_spad_if.sv
// Router/MAC-facing bundle of the PE weight scratchpad.
// master = router/MAC side, slave = scratchpad side.
// WSPAD_PARITY_EN adds the sticky par_err_o status.
interface pe_wght_spad_if #(
  parameter int DATA_BITWIDTH = 16
);

  logic signed [DATA_BITWIDTH-1:0] w_data_i;
  logic                            load_en_i;
  logic                            start_i;
  logic signed [DATA_BITWIDTH-1:0] w_data_o;
  logic                            w_valid_o;
  logic                            w_ready_i;
  logic                            w_last_o;
  logic                            full_o;
  logic                            done_o;
  logic                            ovf_o;
`ifdef WSPAD_PARITY_EN
  logic                            par_err_o;
`endif

  modport master (
    output w_data_i, load_en_i, start_i, w_ready_i,
    input  w_data_o, w_valid_o, w_last_o, full_o, done_o, ovf_o
`ifdef WSPAD_PARITY_EN
    , input par_err_o
`endif
  );

  modport slave (
    input  w_data_i, load_en_i, start_i, w_ready_i,
    output w_data_o, w_valid_o, w_last_o, full_o, done_o, ovf_o
`ifdef WSPAD_PARITY_EN
    , output par_err_o
`endif
  );

endinterface

// File: rtl/wspad_mem.sv
// Weight storage: one write port, combinational read port.
// With WSPAD_PARITY_EN each entry carries an even-parity bit.
module wspad_mem
  import wspad_pkg::*;
#(
  parameter int DATA_BITWIDTH = 16,
  parameter int DEPTH         = 9,
  parameter int IDX_W         = idx_w(DEPTH)
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [IDX_W-1:0]                wr_addr,
  input  logic signed [DATA_BITWIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]                rd_addr,
  output logic signed [DATA_BITWIDTH-1:0] rd_data
`ifdef WSPAD_PARITY_EN
  ,
  output logic                            rd_par
`endif
);

  logic signed [DATA_BITWIDTH-1:0] mem [DEPTH];
`ifdef WSPAD_PARITY_EN
  logic [DEPTH-1:0] par_mem;
`endif

  // Storage is never reset; contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
`ifdef WSPAD_PARITY_EN
      par_mem[wr_addr] <= ^wr_data;
`endif
    end
  end

  assign rd_data = mem[rd_addr];
`ifdef WSPAD_PARITY_EN
  assign rd_par = par_mem[rd_addr];
`endif

endmodule

// File: rtl/pe_wght_spad.sv
// PE weight scratchpad: loads one kernel from the router, then replays it
// to the MAC over valid/ready num_pass times.
// Optional: WSPAD_PARITY_EN (per-entry parity with sticky par_err_o).
module pe_wght_spad
  import wspad_pkg::*;
#(
  parameter int DATA_BITWIDTH      = 16,
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int kernel_size        = 3,
  parameter int act_size           = 5
) (
  input logic            clk,
  input logic            reset,
  pe_wght_spad_if.slave  bus
);

  localparam int NUM_WGHT = num_wght(kernel_size);
  localparam int NUM_PASS = num_pass(act_size, kernel_size);
  localparam int IDX_W    = idx_w(NUM_WGHT);
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] LAST_IDX = ADDR_BITWIDTH_SPAD'(NUM_WGHT - 1);
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] PASS_END = ADDR_BITWIDTH_SPAD'(NUM_PASS);

  generate
    if (NUM_WGHT >= (1 << ADDR_BITWIDTH_SPAD)) begin : g_bad_depth
      $error("pe_wght_spad: kernel does not fit the address counter width");
    end
    if (NUM_PASS < 1 || NUM_PASS >= (1 << ADDR_BITWIDTH_SPAD)) begin : g_bad_pass
      $error("pe_wght_spad: pass count out of range for the counter width");
    end
  endgenerate

  state_t                          state;
  logic [ADDR_BITWIDTH_SPAD-1:0]   wr_cnt;
  logic [ADDR_BITWIDTH_SPAD-1:0]   rd_cnt;
  logic [ADDR_BITWIDTH_SPAD-1:0]   pass_cnt;
  logic signed [DATA_BITWIDTH-1:0] w_data_p0;
  logic                            vld_p0;
  logic                            last_p0;
  logic                            full_q;
  logic                            done_q;
  logic                            ovf_q;

  logic                            wr_en;
  logic [ADDR_BITWIDTH_SPAD-1:0]   rd_idx;
  logic [ADDR_BITWIDTH_SPAD-1:0]   pass_base;
  logic                            rd_last;
  logic                            ld;
  logic                            remain;
  logic                            final_acc;
  logic                            issue;
  logic signed [DATA_BITWIDTH-1:0] rd_data;
`ifdef WSPAD_PARITY_EN
  logic                            rd_par;
  logic                            par_err_q;
`endif

  // Read address, output-register load and end-of-stream decode.
  // Word 0 is issued on the start cycle so it is valid one cycle later.
  always_comb begin
    wr_en     = bus.load_en_i && (state == IDLE || state == LOAD);
    rd_idx    = (state == READY) ? '0 : rd_cnt;
    pass_base = (state == READY) ? '0 : pass_cnt;
    rd_last   = (rd_idx == LAST_IDX);
    ld        = !vld_p0 || bus.w_ready_i;
    remain    = (pass_cnt < PASS_END);
    final_acc = (state == STREAM) && vld_p0 && bus.w_ready_i && last_p0 &&
                (pass_cnt == PASS_END);
    issue     = (state == READY && bus.start_i) ||
                (state == STREAM && ld && remain);
  end

  wspad_mem #(
    .DATA_BITWIDTH (DATA_BITWIDTH),
    .DEPTH         (NUM_WGHT),
    .IDX_W         (IDX_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt[IDX_W-1:0]),
    .wr_data (bus.w_data_i),
    .rd_addr (rd_idx[IDX_W-1:0]),
    .rd_data (rd_data)
`ifdef WSPAD_PARITY_EN
    ,
    .rd_par  (rd_par)
`endif
  );

  // Controller FSM, counters and the MAC-facing output register (stage p0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      pass_cnt  <= '0;
      w_data_p0 <= '0;
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef WSPAD_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;

      // ---- stage p0: memory read -> output register ----
      if (issue) begin
        w_data_p0 <= rd_data;
        vld_p0    <= 1'b1;
        last_p0   <= rd_last;
        rd_cnt    <= rd_last ? '0 : rd_idx + 1'b1;
        pass_cnt  <= pass_base + ADDR_BITWIDTH_SPAD'(rd_last);
`ifdef WSPAD_PARITY_EN
        if (rd_par != ^rd_data) par_err_q <= 1'b1;
`endif
      end else if (final_acc) begin
        vld_p0  <= 1'b0;
        last_p0 <= 1'b0;
      end

      case (state)
        IDLE, LOAD: begin
          if (bus.load_en_i) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST_IDX) begin
              state  <= READY;
              full_q <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        READY: begin
          if (bus.load_en_i) ovf_q <= 1'b1;
          if (bus.start_i)   state <= STREAM;
        end
        STREAM: begin
          if (bus.load_en_i) ovf_q <= 1'b1;
          if (final_acc) begin
            state  <= DONE;
            done_q <= 1'b1;
            full_q <= 1'b0;
          end
        end
        DONE: begin
          if (bus.load_en_i) ovf_q <= 1'b1;
          wr_cnt <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.w_data_o  = w_data_p0;
  assign bus.w_valid_o = vld_p0;
  assign bus.w_last_o  = last_p0;
  assign bus.full_o    = full_q;
  assign bus.done_o    = done_q;
  assign bus.ovf_o     = ovf_q;
`ifdef WSPAD_PARITY_EN
  assign bus.par_err_o = par_err_q;
`endif

endmodule
